evt_readout_ctrl: RTL and testbench

- Sequences readout of the hierarchical pixel arbiter tree. Watches the tree's top-level active flag, pulses the group enable to take one grant, captures the granted pixel's x/y address, and waits for the group-release handshake.
- Pushes each captured event into an internal FIFO. The FIFO drains to downstream logic over a valid/ready interface.
- Sits between the top pixel_groups level and the event output path.

---
 rtl/evt_readout_ctrl_pkg.sv | 17 +
 rtl/evt_readout_ctrl_if.sv | 28 ++
 rtl/evt_readout_ctrl_fifo.sv | 52 +++++
 rtl/evt_readout_ctrl.sv | 129 ++++++++++++
 tb/tb_evt_readout_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/evt_readout_ctrl_pkg.sv
// Shared types and default sizes for the pixel arbiter readout path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: rd_state_t readout FSM states, default timestamp width and FIFO depth.
package lib_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    CAPT = 2'd2,
    WREL = 2'd3
  } rd_state_t;

  localparam int DEF_TS_W       = 16;
  localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/evt_readout_ctrl_if.sv
// Handshake bundle between the arbiter tree, the readout controller and the event sink.
// Latency: n/a (wires only).
// Backpressure: evt_ready_i stalls the event head; grp_enable_o is the tree's go signal.
// master: controller side (drives grp_enable_o, evt_valid_o, evt_data_o).
// slave: environment side (drives active_i, x/y address, grp_release_i, evt_ready_i).
interface evt_readout_ctrl_if #(
  parameter int ADD_W = 4,
  parameter int EVT_W = 8
);
  logic             active_i;
  logic [ADD_W-1:0] x_add_i;
  logic [ADD_W-1:0] y_add_i;
  logic             grp_release_i;
  logic             grp_enable_o;
  logic             evt_valid_o;
  logic [EVT_W-1:0] evt_data_o;
  logic             evt_ready_i;

  modport master (
    input  active_i, x_add_i, y_add_i, grp_release_i, evt_ready_i,
    output grp_enable_o, evt_valid_o, evt_data_o
  );

  modport slave (
    output active_i, x_add_i, y_add_i, grp_release_i, evt_ready_i,
    input  grp_enable_o, evt_valid_o, evt_data_o
  );
endinterface

// File: rtl/evt_readout_ctrl_fifo.sv
// Event FIFO, first-word-fall-through, with extra pointer bit for full/empty.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push is dropped only when full without a simultaneous pop; head holds until popped.
// Ports: clk_i, reset_i (sync, active-low), push_i/push_data_i, pop_i, valid_o/pop_data_o, full_o, empty_o.
module evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign valid_o = !empty_o;

  // At full a push is only accepted together with a pop that frees the slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign pop_data_o = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_q[AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/evt_readout_ctrl.sv
// Readout sequencer for the pixel arbiter tree: take one grant, capture x/y, wait for release, queue the event.
// Latency: active_i to grp_enable_o 1 cycle; CAPT to evt_valid_o 1 cycle; at least 4 cycles per event.
// Backpressure: a full event FIFO holds the FSM in IDLE, so active_i is ignored until the sink drains.
// Ports: clk_i, reset_i (sync, active-low), bus (evt_readout_ctrl_if.master), evt_count_o, err_timeout_o, busy_o.
// Build option EVT_TIMESTAMP_EN: when defined the event word is {ts, y, x}, otherwise {y, x}.
module evt_readout_ctrl
  import lib_arbiter_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int ADD_W       = 4,
  parameter int TS_W        = DEF_TS_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int REL_TIMEOUT = 64
) (
  input  logic                clk_i,
  input  logic                reset_i,
  evt_readout_ctrl_if.master  bus,
  output logic [15:0]         evt_count_o,
  output logic                err_timeout_o,
  output logic                busy_o
);
`ifdef EVT_TIMESTAMP_EN
  localparam int EVT_W = TS_W + 2 * ADD_W;
`else
  localparam int EVT_W = 2 * ADD_W;
`endif
  localparam int TO_W = (REL_TIMEOUT > 1) ? $clog2(REL_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(REL_TIMEOUT - 1);

  if (((1 << ADD_W) != ROWS) || ((1 << ADD_W) != COLS) || (FIFO_DEPTH < 2) || (TS_W < 1))
  begin : g_cfg_err
    $error("evt_readout_ctrl: inconsistent parameters");
  end

  rd_state_t        state_q, state_d;
  logic             push;
  logic             to_clr, to_inc, to_hit;
  logic [TO_W-1:0]  to_q;
  logic [EVT_W-1:0] evt_word;
  logic [EVT_W-1:0] fifo_data;
  logic             fifo_valid, fifo_full, fifo_empty;

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.grp_enable_o = 1'b0;
    push             = 1'b0;
    to_clr           = 1'b0;
    to_inc           = 1'b0;
    to_hit           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.active_i && !fifo_full) state_d = ARB;
      end
      ARB: begin
        bus.grp_enable_o = 1'b1;
        state_d          = CAPT;
      end
      CAPT: begin
        // Occupancy cannot have grown since IDLE checked full, so this push always lands.
        push    = 1'b1;
        to_clr  = 1'b1;
        state_d = WREL;
      end
      WREL: begin
        if (bus.grp_release_i) begin
          state_d = IDLE;
        end else if (to_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      to_q          <= '0;
      err_timeout_o <= 1'b0;
      evt_count_o   <= '0;
    end else begin
      if (to_clr)      to_q <= '0;
      else if (to_inc) to_q <= to_q + 1'b1;
      if (to_hit) err_timeout_o <= 1'b1;
      if (push && (evt_count_o != 16'hFFFF)) evt_count_o <= evt_count_o + 16'd1;
    end
  end

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) ts_q <= '0;
    else          ts_q <= ts_q + 1'b1;
  end

  assign evt_word = {ts_q, bus.y_add_i, bus.x_add_i};
`else
  assign evt_word = {bus.y_add_i, bus.x_add_i};
`endif

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_data_i (evt_word),
    .pop_i       (bus.evt_ready_i),
    .valid_o     (fifo_valid),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Memory is not reset, so the head word is forced to zero while nothing is queued.
  assign bus.evt_valid_o = fifo_valid;
  assign bus.evt_data_o  = fifo_empty ? '0 : fifo_data;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_evt_readout_ctrl.sv
// Bench for evt_readout_ctrl: directed steps plus a random phase against a queue-based event model.
// Latency: n/a.
// Backpressure: evt_ready_i is driven low/high/random to exercise full and drain.
module tb_evt_readout_ctrl;
  localparam int ADD_W       = 4;
  localparam int DEPTH       = 8;
  localparam int REL_TIMEOUT = 64;
`ifdef EVT_TIMESTAMP_EN
  localparam int TS_W  = 4;
  localparam int EVT_W = TS_W + 2 * ADD_W;
`else
  localparam int TS_W  = 16;
  localparam int EVT_W = 2 * ADD_W;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cnt;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  evt_readout_ctrl_if #(.ADD_W(ADD_W), .EVT_W(EVT_W)) bus ();

  evt_readout_ctrl #(
    .ROWS(16), .COLS(16), .ADD_W(ADD_W), .TS_W(TS_W),
    .FIFO_DEPTH(DEPTH), .REL_TIMEOUT(REL_TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst_n),
    .bus           (bus.master),
    .evt_count_o   (cnt),
    .err_timeout_o (err),
    .busy_o        (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queued words, pushes counted, timestamp = edges since reset.
  logic [EVT_W-1:0] q[$];
  int  cnt_m     = 0;
  int  ts_m      = 0;
  bit  capt_pend = 0;
  bit  prev_en   = 0;
  int  n_en      = 0;
  int  n_pop     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EVT_W-1:0] mk_word(input int ts, input logic [ADD_W-1:0] y,
                                               input logic [ADD_W-1:0] x);
`ifdef EVT_TIMESTAMP_EN
    return {TS_W'(ts), y, x};
`else
    return {y, x};
`endif
  endfunction

  // One clock: apply what the coming edge does to the model, advance, then compare.
  task automatic step();
    if (rst_n) begin
      if (bus.evt_valid_o && bus.evt_ready_i && q.size() > 0) begin
        void'(q.pop_front());
        n_pop++;
      end
      // The cycle after a grant pulse is the capture cycle.
      if (capt_pend) begin
        q.push_back(mk_word(ts_m, bus.y_add_i, bus.x_add_i));
        if (cnt_m < 65535) cnt_m++;
      end
      capt_pend = bus.grp_enable_o;
      if (bus.grp_enable_o) n_en++;
    end else begin
      capt_pend = 0;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
      ts_m  = 0;
    end else begin
      ts_m = (ts_m + 1) % (1 << TS_W);
    end
    chk("evt_valid", {31'd0, bus.evt_valid_o}, {31'd0, q.size() != 0});
    chk("evt_count", {16'd0, cnt}, cnt_m);
    if (q.size() != 0) chk("evt_data", 32'(bus.evt_data_o), 32'(q[0]));
    else               chk("evt_data_idle", 32'(bus.evt_data_o), 32'd0);
    if (bus.grp_enable_o) chk("enable_while_full", {31'd0, q.size() < DEPTH}, 32'd1);
    chk("enable_width", {31'd0, prev_en & bus.grp_enable_o}, 32'd0);
    prev_en = bus.grp_enable_o;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int en0;
    int pop0;
    bit done;

    rst_n             = 1'b0;
    bus.active_i      = 1'b1;
    bus.x_add_i       = 4'd3;
    bus.y_add_i       = 4'd5;
    bus.grp_release_i = 1'b0;
    bus.evt_ready_i   = 1'b1;

    // Reset with active high: everything quiet.
    repeat (3) step();
    chk("rst_grp_enable", {31'd0, bus.grp_enable_o}, 32'd0);
    chk("rst_evt_valid", {31'd0, bus.evt_valid_o}, 32'd0);
    chk("rst_evt_data", 32'(bus.evt_data_o), 32'd0);
    chk("rst_count", {16'd0, cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single event x=3 y=5, release two cycles after capture.
    rst_n = 1'b1;
    chk("pre_arb_enable", {31'd0, bus.grp_enable_o}, 32'd0);
    step();
    chk("arb_enable", {31'd0, bus.grp_enable_o}, 32'd1);
    chk("arb_busy", {31'd0, busy}, 32'd1);
    bus.active_i = 1'b0;
    step();
    chk("capt_enable_low", {31'd0, bus.grp_enable_o}, 32'd0);
    step();
    chk("first_valid", {31'd0, bus.evt_valid_o}, 32'd1);
    chk("first_xy", {24'd0, bus.evt_data_o[2*ADD_W-1:0]}, 32'h53);
    chk("first_count", {16'd0, cnt}, 32'd1);
    step();
    chk("wrel_busy", {31'd0, busy}, 32'd1);
    bus.grp_release_i = 1'b1;
    step();
    chk("release_busy", {31'd0, busy}, 32'd0);

    // Backpressure: ten requests, ready low, only eight fit.
    bus.evt_ready_i = 1'b0;
    bus.active_i    = 1'b1;
    en0  = n_en;
    pop0 = n_pop;
    for (int i = 0; i < 60; i++) begin
      bus.x_add_i = 4'($urandom_range(0, 15));
      bus.y_add_i = 4'($urandom_range(0, 15));
      step();
    end
    chk("full_grants", n_en - en0, 32'd8);
    chk("full_count", {16'd0, cnt}, 32'd9);
    chk("full_enable_low", {31'd0, bus.grp_enable_o}, 32'd0);
    bus.evt_ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (n_en - en0 >= 10) bus.active_i = 1'b0;
      bus.x_add_i = 4'($urandom_range(0, 15));
      bus.y_add_i = 4'($urandom_range(0, 15));
      step();
    end
    chk("drain_grants", n_en - en0, 32'd10);
    chk("drain_pops", n_pop - pop0, 32'd10);
    chk("drain_count", {16'd0, cnt}, 32'd11);

    // Release never comes: timeout after REL_TIMEOUT cycles in WREL.
    bus.grp_release_i = 1'b0;
    bus.active_i      = 1'b1;
    n = 0;
    while (!bus.grp_enable_o && n < 20) begin step(); n++; end
    chk("to_grant_seen", {31'd0, bus.grp_enable_o}, 32'd1);
    bus.active_i = 1'b0;
    step();
    step();
    n = 0;
    while (!err && n < 200) begin step(); n++; end
    chk("timeout_cycles", n, REL_TIMEOUT);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    bus.grp_release_i = 1'b1;
    bus.active_i      = 1'b1;
    n = 0;
    while (!bus.grp_enable_o && n < 20) begin step(); n++; end
    chk("serve_after_timeout", {31'd0, bus.grp_enable_o}, 32'd1);
    bus.active_i = 1'b0;
    repeat (10) step();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset while waiting for release with three words queued.
    bus.evt_ready_i   = 1'b0;
    bus.grp_release_i = 1'b1;
    bus.active_i      = 1'b1;
    k    = 0;
    done = 0;
    for (int i = 0; i < 60; i++) begin
      if (!done) begin
        if (bus.grp_enable_o) begin
          k++;
          if (k == 3) begin
            bus.active_i      = 1'b0;
            bus.grp_release_i = 1'b0;
            done              = 1;
          end
        end
        if (!done || k == 3) step();
      end
    end
    step();
    step();
    chk("queued_busy", {31'd0, busy}, 32'd1);
    chk("queued_valid", {31'd0, bus.evt_valid_o}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", {31'd0, bus.evt_valid_o}, 32'd0);
    chk("midrst_count", {16'd0, cnt}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("no_stale_word", {31'd0, bus.evt_valid_o}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.active_i      = ($urandom_range(0, 2) != 0);
      bus.evt_ready_i   = $urandom_range(0, 1) == 1;
      bus.grp_release_i = ($urandom_range(0, 2) == 0);
      bus.x_add_i       = 4'($urandom_range(0, 15));
      bus.y_add_i       = 4'($urandom_range(0, 15));
      step();
    end
    bus.active_i      = 1'b0;
    bus.evt_ready_i   = 1'b1;
    bus.grp_release_i = 1'b1;
    repeat (20) step();
    chk("random_drained", {31'd0, bus.evt_valid_o}, 32'd0);

`ifdef EVT_TIMESTAMP_EN
    // Timestamp capture at 15 and again at 2 after the counter wraps.
    rst_n = 1'b0;
    step();
    rst_n           = 1'b1;
    bus.evt_ready_i = 1'b0;
    n = 0;
    while (ts_m != 13 && n < 40) begin step(); n++; end
    bus.active_i = 1'b1;
    step();
    bus.active_i = 1'b0;
    step();
    step();
    step();
    n = 0;
    while (ts_m != 0 && n < 40) begin step(); n++; end
    bus.active_i = 1'b1;
    step();
    bus.active_i = 1'b0;
    repeat (3) step();
    chk("ts_first", {28'd0, bus.evt_data_o[EVT_W-1:2*ADD_W]}, 32'd15);
    bus.evt_ready_i = 1'b1;
    step();
    bus.evt_ready_i = 1'b0;
    chk("ts_second", {28'd0, bus.evt_data_o[EVT_W-1:2*ADD_W]}, 32'd2);
    bus.evt_ready_i = 1'b1;
    repeat (3) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
